// File: rtl/booth_r4_mult_param_if.sv
// Operand/result bus for the radix-4 Booth multiplier: start/mode/operand in,
// busy/done/product out.
interface booth_r4_mult_param_if #(
    parameter int WIDTH = 8
);
    logic                   start;
    logic                   signed_mode;
    logic [WIDTH-1:0]       inbus;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     product;

    modport master (
        output start, signed_mode, inbus,
        input  busy, done, product
    );

    modport slave (
        input  start, signed_mode, inbus,
        output busy, done, product
    );
endinterface

// File: rtl/booth_r4_mult_param.sv
// Radix-4 Booth multiplier: multiplicand then multiplier over a shared bus,
// signed or unsigned operands, fixed latency, full 2*WIDTH-bit product.
//
// state  | meaning
// IDLE   | waiting for start; multiplicand captured on the accepting edge
// LOAD_Q | capture multiplier, clear accumulator and step counter
// CALC   | one Booth digit per cycle; last step loads product and pulses done
module booth_r4_mult_param #(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    booth_r4_mult_param_if.slave  bus
);
    localparam int N    = WIDTH + 2;
    localparam int ITER = N / 2;
    localparam int CW   = $clog2(ITER + 1);

    generate
        if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
            $error("booth_r4_mult_param: WIDTH must be even and >= 4");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, LOAD_Q, CALC} state_t;

    state_t                 state_q, state_d;
    logic [N-1:0]           m_q, m_d;
    logic [N-1:0]           q_q, q_d;
    logic                   qm1_q, qm1_d;
    logic [N:0]             a_q, a_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   mode_q, mode_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [2*WIDTH-1:0]     prod_q, prod_d;

    logic [N:0]             m_ext, addend, sum;
    logic [2*N+1:0]         step;
    logic                   last_step;

    // Two extra bits let unsigned operands ride the same signed datapath.
    function automatic logic [N-1:0] ext(input logic [WIDTH-1:0] x, input logic s);
        return {{2{s & x[WIDTH-1]}}, x};
    endfunction

    assign last_step = (cnt_q == CW'(ITER - 1));

    always_comb begin
        m_ext = {m_q[N-1], m_q};
        case ({q_q[1:0], qm1_q})
            3'b001, 3'b010: addend = m_ext;
            3'b011:         addend = m_ext << 1;
            3'b100:         addend = -(m_ext << 1);
            3'b101, 3'b110: addend = -m_ext;
            default:        addend = '0;
        endcase
        sum  = a_q + addend;
        step = $unsigned($signed({sum, q_q, qm1_q}) >>> 2);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            m_q     <= '0;
            q_q     <= '0;
            qm1_q   <= 1'b0;
            a_q     <= '0;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            q_q     <= q_d;
            qm1_q   <= qm1_d;
            a_q     <= a_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            prod_q  <= prod_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = LOAD_Q;
            LOAD_Q:  state_d = CALC;
            CALC:    if (last_step) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        m_d    = m_q;
        q_d    = q_q;
        qm1_d  = qm1_q;
        a_d    = a_q;
        cnt_d  = cnt_q;
        mode_d = mode_q;
        prod_d = prod_q;
        done_d = 1'b0;
        busy_d = (state_d != IDLE);
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    m_d    = ext(bus.inbus, bus.signed_mode);
                    mode_d = bus.signed_mode;
                end
            end
            LOAD_Q: begin
                q_d   = ext(bus.inbus, mode_q);
                qm1_d = 1'b0;
                a_d   = '0;
                cnt_d = '0;
            end
            CALC: begin
                a_d   = step[2*N+1:N+1];
                q_d   = step[N:1];
                qm1_d = step[0];
                cnt_d = cnt_q + 1'b1;
                if (last_step) begin
                    prod_d = step[2*WIDTH:1];
                    done_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.product = prod_q;
endmodule

// File: tb/tb_booth_r4_mult_param.sv
// Bench for booth_r4_mult_param at WIDTH 8, 16 and 4 against an integer a*b model.
module tb_booth_r4_mult_param;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    booth_r4_mult_param_if #(.WIDTH(8))  if8();
    booth_r4_mult_param_if #(.WIDTH(16)) if16();
    booth_r4_mult_param_if #(.WIDTH(4))  if4();

    booth_r4_mult_param #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(if8));
    booth_r4_mult_param #(.WIDTH(16)) dut16 (.clk(clk), .reset(reset), .bus(if16));
    booth_r4_mult_param #(.WIDTH(4))  dut4  (.clk(clk), .reset(reset), .bus(if4));

    int n_assert = 0;
    int n_fail   = 0;

    task automatic drive(input int w, input logic st, input logic md, input logic [15:0] d);
        case (w)
            8:  begin if8.start  = st; if8.signed_mode  = md; if8.inbus  = d[7:0];  end
            16: begin if16.start = st; if16.signed_mode = md; if16.inbus = d;       end
            4:  begin if4.start  = st; if4.signed_mode  = md; if4.inbus  = d[3:0];  end
            default: ;
        endcase
    endtask

    function automatic logic dut_done(input int w);
        case (w)
            8:       return if8.done;
            16:      return if16.done;
            default: return if4.done;
        endcase
    endfunction

    function automatic logic [31:0] dut_prod(input int w);
        case (w)
            8:       return {16'h0, if8.product};
            16:      return if16.product;
            default: return {24'h0, if4.product};
        endcase
    endfunction

    function automatic logic [15:0] wmask(input int w);
        return 16'((32'd1 << w) - 1);
    endfunction

    // Interpret operands as integers per mode and multiply; keep the low 2w bits.
    function automatic logic [31:0] ref_mul(input logic [15:0] m, input logic [15:0] q,
                                            input logic md, input int w);
        longint a, b, p;
        a = longint'(m & wmask(w));
        b = longint'(q & wmask(w));
        if (md && m[w-1]) a = a - (longint'(1) << w);
        if (md && q[w-1]) b = b - (longint'(1) << w);
        p = a * b;
        return 32'(p & ((longint'(1) << (2*w)) - 1));
    endfunction

    // Issue one operation starting in the current cycle; returns when done is seen.
    task automatic run_op(input int w, input logic [15:0] m, input logic [15:0] q,
                          input logic md, input int glitch_k,
                          output logic [31:0] p, output int lat, output logic [31:0] p_mid);
        drive(w, 1'b1, md, m);
        @(posedge clk); #1;
        drive(w, 1'b0, md, q);
        lat   = 0;
        p     = '0;
        p_mid = dut_prod(w);
        for (int k = 1; k <= 40; k++) begin
            if (k == glitch_k) drive(w, 1'b1, 1'($urandom), 16'($urandom));
            else if (k >= 2)   drive(w, 1'b0, 1'($urandom), 16'($urandom));
            @(posedge clk); #1;
            if (k == 2) p_mid = dut_prod(w);
            if (dut_done(w)) begin
                lat = k;
                p   = dut_prod(w);
                break;
            end
        end
        drive(w, 1'b0, 1'b0, 16'h0);
        n_assert++;
        if (lat == 0) begin
            n_fail++;
            $display("FAIL done_timeout w=%0d m=%h q=%h: got no done within 40 cycles, required one", w, m, q);
        end
    endtask

    logic pd8 = 1'b0, pd16 = 1'b0, pd4 = 1'b0;
    always @(negedge clk) begin
        n_assert++;
        if ((if8.busy && if8.done) || (if16.busy && if16.done) || (if4.busy && if4.done)) begin
            n_fail++;
            $display("FAIL busy_done_overlap: busy/done 8:%b%b 16:%b%b 4:%b%b, required never both 1",
                     if8.busy, if8.done, if16.busy, if16.done, if4.busy, if4.done);
        end
        n_assert++;
        if ((pd8 && if8.done) || (pd16 && if16.done) || (pd4 && if4.done)) begin
            n_fail++;
            $display("FAIL done_width: done high two cycles in a row (8:%b 16:%b 4:%b), required one cycle",
                     if8.done, if16.done, if4.done);
        end
        pd8  <= if8.done;
        pd16 <= if16.done;
        pd4  <= if4.done;
    end

    task automatic test_reset();
        reset = 1'b1;
        drive(8, 0, 0, 0); drive(16, 0, 0, 0); drive(4, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        n_assert++;
        if ({if8.busy, if8.done, if16.busy, if16.done, if4.busy, if4.done} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_flags: busy/done = %b%b %b%b %b%b, required all 0",
                     if8.busy, if8.done, if16.busy, if16.done, if4.busy, if4.done);
        end
        n_assert++;
        if (if8.product !== 16'h0 || if16.product !== 32'h0 || if4.product !== 8'h0) begin
            n_fail++;
            $display("FAIL reset_product: got %h %h %h, required 0", if8.product, if16.product, if4.product);
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [15:0] tm [5] = '{16'h80, 16'hC8, 16'hC8, 16'hFF, 16'h7F};
        logic [15:0] tq [5] = '{16'h80, 16'h03, 16'h03, 16'hFF, 16'h80};
        logic        tmd[5] = '{1'b1,   1'b1,   1'b0,   1'b0,   1'b1};
        logic [31:0] texp[5] = '{32'h4000, 32'hFF58, 32'h0258, 32'hFE01, 32'hC080};
        logic [31:0] p, pm;
        int lat;
        for (int i = 0; i < 5; i++) begin
            run_op(8, tm[i], tq[i], tmd[i], 0, p, lat, pm);
            n_assert++;
            if (p !== texp[i]) begin
                n_fail++;
                $display("FAIL directed_product %h x %h mode=%b: got %h, required %h", tm[i], tq[i], tmd[i], p, texp[i]);
            end
            n_assert++;
            if (lat != 6) begin
                n_fail++;
                $display("FAIL directed_latency: got %0d edges, required 6", lat);
            end
        end
    endtask

    task automatic test_start_while_busy();
        logic [31:0] p, pm, exp;
        int lat;
        bit extra;
        exp = ref_mul(16'h12, 16'hB4, 1'b1, 8);
        run_op(8, 16'h12, 16'hB4, 1'b1, 3, p, lat, pm);
        n_assert++;
        if (p !== exp || lat != 6) begin
            n_fail++;
            $display("FAIL busy_start_result: got %h lat %0d, required %h lat 6", p, lat, exp);
        end
        extra = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            if (if8.done || if8.busy) extra = 1'b1;
        end
        n_assert++;
        if (extra !== 1'b0 || if8.product !== exp[15:0]) begin
            n_fail++;
            $display("FAIL busy_start_queued: activity=%b product=%h, required 0 and %h", extra, if8.product, exp[15:0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] p1, p2, pm, e1, e2;
        int lat;
        e1 = ref_mul(16'h9D, 16'h6E, 1'b1, 8);
        e2 = ref_mul(16'hE3, 16'hF1, 1'b0, 8);
        run_op(8, 16'h9D, 16'h6E, 1'b1, 0, p1, lat, pm);
        run_op(8, 16'hE3, 16'hF1, 1'b0, 0, p2, lat, pm);
        n_assert++;
        if (p1 !== e1 || p2 !== e2) begin
            n_fail++;
            $display("FAIL b2b_product: got %h,%h, required %h,%h", p1, p2, e1, e2);
        end
        n_assert++;
        if (lat != 6) begin
            n_fail++;
            $display("FAIL b2b_latency: got %0d, required 6", lat);
        end
        n_assert++;
        if (pm !== e1) begin
            n_fail++;
            $display("FAIL b2b_product_hold: got %h during second op, required %h", pm, e1);
        end
    endtask

    task automatic test_reset_midop();
        logic [31:0] p, pm, exp;
        int lat;
        bit seen;
        drive(8, 1'b1, 1'b1, 16'h5A);
        @(posedge clk); #1;
        drive(8, 1'b0, 1'b1, 16'h33);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        n_assert++;
        if (if8.busy !== 1'b0 || if8.done !== 1'b0 || if8.product !== 16'h0) begin
            n_fail++;
            $display("FAIL midop_reset: busy=%b done=%b product=%h, required 0 0 0000", if8.busy, if8.done, if8.product);
        end
        reset = 1'b0;
        seen = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            if (if8.done) seen = 1'b1;
        end
        n_assert++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL midop_late_done: got a done pulse after reset, required none");
        end
        exp = ref_mul(16'hA7, 16'h3C, 1'b1, 8);
        run_op(8, 16'hA7, 16'h3C, 1'b1, 0, p, lat, pm);
        n_assert++;
        if (p !== exp || lat != 6) begin
            n_fail++;
            $display("FAIL midop_recover: got %h lat %0d, required %h lat 6", p, lat, exp);
        end
    endtask

    task automatic test_random(input int w, input int count);
        logic [15:0] mask, m, q;
        logic [15:0] corner[4];
        logic md;
        logic [31:0] p, pm, exp;
        int lat;
        mask = wmask(w);
        corner = '{16'h0, mask, mask ^ (mask >> 1), mask >> 1};
        for (int i = 0; i < count; i++) begin
            if (i < 32) begin
                m  = corner[i % 4];
                q  = corner[(i / 4) % 4];
                md = (i >= 16);
            end else begin
                m  = 16'($urandom) & mask;
                q  = 16'($urandom) & mask;
                md = 1'($urandom);
            end
            exp = ref_mul(m, q, md, w);
            run_op(w, m, q, md, 0, p, lat, pm);
            n_assert++;
            if (p !== exp) begin
                n_fail++;
                $display("FAIL random_product w=%0d %h x %h mode=%b: got %h, required %h", w, m, q, md, p, exp);
            end
            n_assert++;
            if (lat != w / 2 + 2) begin
                n_fail++;
                $display("FAIL random_latency w=%0d: got %0d, required %0d", w, lat, w / 2 + 2);
            end
            if ($urandom_range(3) == 0) begin
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_start_while_busy();
        test_back_to_back();
        test_reset_midop();
        test_random(8, 1000);
        test_random(16, 3000);
        test_random(4, 3000);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
